// File: rtl/fir_pkg.sv
// Shared FIR constants and fixed-point helpers.
// Holds the FIR output width and the sat_round model function.
package fir_pkg;

  localparam int DATA_WIDTH  = 18;
  localparam int COEFF_WIDTH = 18;
  localparam int N_TAPS      = 4;

  function automatic int fir_out_width(
    input int dw,
    input int cw,
    input int nt
  );
    return dw + cw + $clog2(nt);
  endfunction

  localparam int FIR_OUT_WIDTH =
    fir_out_width(DATA_WIDTH, COEFF_WIDTH, N_TAPS);

  // Round half toward +inf, shift right by frac,
  // clip to a signed ow-bit range.
  function automatic logic signed [63:0] sat_round(
    input logic signed [63:0] x,
    input int                 frac,
    input int                 ow
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (x + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/fir_out_quantizer_if.sv
// Sample-stream bundle: FIR input strobe/data, output valid/ready/data.
// slave = quantizer side, master = producer/consumer side.
interface fir_out_quantizer_if
  import fir_pkg::*;
#(
  parameter int IN_WIDTH  = FIR_OUT_WIDTH,
  parameter int OUT_WIDTH = 18
);

  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous FIFO: push/pop/clear, full/empty/level, head on dout.
// Pointers carry one extra wrap bit; dout reads 0 while empty.
module fir_out_fifo
  import fir_pkg::*;
#(
  parameter  int W     = 18,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  wr_d;
  logic [AW:0]  rd_q;
  logic [AW:0]  rd_d;
  logic         do_push;
  logic         do_pop;

  assign level = wr_q - rd_q;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  // A pop on full frees the slot the push needs.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    if (clear) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_out_quantizer.sv
// FIR output quantizer: decimate, round, saturate, buffer, valid/ready.
// Optional FIR_OUT_SAT_CNT_EN enables the saturated-sample counter.
module fir_out_quantizer
  import fir_pkg::*;
#(
  parameter  int IN_WIDTH   = FIR_OUT_WIDTH,
  parameter  int OUT_WIDTH  = 18,
  parameter  int FRAC_SHIFT = 17,
  parameter  int DECIM_MAX  = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int PW         = $clog2(DECIM_MAX + 1),
  localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic [PW-1:0]         decim_ratio,
  fir_out_quantizer_if.slave    bus,
  output logic [LW-1:0]         fifo_level,
  output logic                  overflow,
  output logic [15:0]           sat_count
);

  localparam int RW = IN_WIDTH + 1 - FRAC_SHIFT;

  localparam logic signed [IN_WIDTH:0] HALF =
    (IN_WIDTH+1)'(1) << (FRAC_SHIFT - 1);

  localparam logic signed [RW-1:0] SAT_HI =
    RW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);

  localparam logic signed [RW-1:0] SAT_LO =
    RW'(-(64'sd1 <<< (OUT_WIDTH - 1)));

  logic [PW-1:0]            phase_q;
  logic [PW-1:0]            phase_d;
  logic [PW-1:0]            ratio_q;
  logic [PW-1:0]            ratio_d;
  logic [PW-1:0]            ratio_in;
  logic [PW-1:0]            period;
  logic                     keep;
  logic signed [IN_WIDTH:0] a_sum;
  logic                     a_valid_q;
  logic                     a_valid_d;
  logic signed [RW-1:0]     a_data_q;
  logic signed [RW-1:0]     a_data_d;
  logic                     b_clip_hi;
  logic                     b_clip_lo;
  logic [OUT_WIDTH-1:0]     b_data;
  logic                     overflow_q;
  logic                     overflow_d;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     pop;
  logic                     drop;

  assign ratio_in =
    (decim_ratio == '0)             ? PW'(1) :
    (decim_ratio > PW'(DECIM_MAX))  ? PW'(DECIM_MAX) :
                                      decim_ratio;

  // One extra bit so adding the rounding half never wraps.
  assign a_sum =
    {bus.in_data[IN_WIDTH-1], bus.in_data} + HALF;

  // The period length is latched at phase 0 and held
  // until the phase wraps back.
  always_comb begin
    phase_d   = phase_q;
    ratio_d   = ratio_q;
    keep      = 1'b0;
    period    = (phase_q == '0) ? ratio_in : ratio_q;
    if (bus.in_valid) begin
      keep    = (phase_q == '0);
      ratio_d = period;
      phase_d = (phase_q == period - PW'(1)) ?
                '0 : phase_q + PW'(1);
    end
    a_valid_d = keep;
    a_data_d  = a_data_q;
    if (keep) a_data_d = RW'(a_sum >>> FRAC_SHIFT);
    overflow_d = overflow_q | drop;
    if (clear) begin
      phase_d    = '0;
      ratio_d    = PW'(1);
      a_valid_d  = 1'b0;
      overflow_d = 1'b0;
    end
  end

  assign b_clip_hi = (a_data_q > SAT_HI);
  assign b_clip_lo = (a_data_q < SAT_LO);

  always_comb begin
    b_data = OUT_WIDTH'(a_data_q);
    unique case (1'b1)
      b_clip_hi: b_data = OUT_WIDTH'(SAT_HI);
      b_clip_lo: b_data = OUT_WIDTH'(SAT_LO);
      default:   b_data = OUT_WIDTH'(a_data_q);
    endcase
  end

  assign pop  = !fifo_empty && bus.out_ready;
  assign drop = a_valid_q && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= '0;
      ratio_q    <= PW'(1);
      a_valid_q  <= 1'b0;
      a_data_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      ratio_q    <= ratio_d;
      a_valid_q  <= a_valid_d;
      a_data_q   <= a_data_d;
      overflow_q <= overflow_d;
    end
  end

  fir_out_fifo #(
    .W     (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (a_valid_q),
    .din     (b_data),
    .pop     (pop),
    .dout    (bus.out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bus.out_valid = !fifo_empty;
  assign overflow      = overflow_q;

`ifdef FIR_OUT_SAT_CNT_EN
  logic [15:0] sat_cnt_q;
  logic [15:0] sat_cnt_d;
  logic        b_clip;

  assign b_clip = b_clip_hi | b_clip_lo;

  // Dropped samples still count: clipping happens before the FIFO.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (a_valid_q && b_clip && sat_cnt_q != 16'hFFFF)
      sat_cnt_d = sat_cnt_q + 16'd1;
    if (clear) sat_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sat_cnt_q <= '0;
    else          sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed testbench for fir_out_quantizer.
// Scenario tasks with inline checks; one summary line at the end.
module tb_fir_out_quantizer;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic [4:0]  decim_ratio;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic [15:0] sat_count;

  int n_checks;
  int n_fail;

  fir_out_quantizer_if bus ();

  fir_out_quantizer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .decim_ratio (decim_ratio),
    .bus         (bus),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .sat_count   (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input longint d);
    bus.in_valid = 1'b1;
    bus.in_data  = 38'(d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b exp 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_data !== 18'sd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0d exp 0", bus.out_data);
    end
    n_checks++;
    if (fifo_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_level: got %0d exp 0", fifo_level);
    end
    n_checks++;
    if (overflow !== 1'b0 || sat_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_flags: ovf %b sat %0d exp 0 0",
               overflow, sat_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    push(longint'(5) <<< 17);
    idle(0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_early: valid %b exp 0", bus.out_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 18'sd5 ||
        fifo_level !== 3'd1) begin
      n_fail++;
      $display("FAIL lat_out: v %b d %0d lvl %0d exp 1 5 1",
               bus.out_valid, bus.out_data, fifo_level);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_pop: valid %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_rounding();
    longint din [4];
    int     exp [4];
    din = '{(longint'(3) <<< 17),
            (longint'(3) <<< 17) + 65536,
            -65536,
            -65537};
    exp = '{3, 4, 0, -1};
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(din[i]);
    idle(1);
    n_checks++;
    if (fifo_level !== 3'd4) begin
      n_fail++;
      $display("FAIL round_level: got %0d exp 4", fifo_level);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_data !== 18'(exp[i])) begin
        n_fail++;
        $display("FAIL round_%0d: v %b got %0d exp %0d",
                 i, bus.out_valid, bus.out_data, exp[i]);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_saturation();
    int exp_sat;
`ifdef FIR_OUT_SAT_CNT_EN
    exp_sat = 2;
`else
    exp_sat = 0;
`endif
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    push(longint'(1) <<< 36);
    push(-(longint'(1) <<< 36));
    idle(1);
    n_checks++;
    if (bus.out_data !== 18'sd131071) begin
      n_fail++;
      $display("FAIL sat_hi: got %0d exp 131071", bus.out_data);
    end
    n_checks++;
    if (sat_count !== 16'(exp_sat)) begin
      n_fail++;
      $display("FAIL sat_count: got %0d exp %0d",
               sat_count, exp_sat);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_data !== -18'sd131072) begin
      n_fail++;
      $display("FAIL sat_lo: got %0d exp -131072", bus.out_data);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_decimation();
    int exp_a [3];
    int exp_b [4];
    exp_a = '{1, 4, 7};
    exp_b = '{1, 4, 6, 8};
    do_clear();
    decim_ratio   = 5'd3;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) push(longint'(k) <<< 17);
    idle(1);
    n_checks++;
    if (fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL dec3_level: got %0d exp 3", fifo_level);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_data !== 18'(exp_a[i])) begin
        n_fail++;
        $display("FAIL dec3_%0d: v %b got %0d exp %0d",
                 i, bus.out_valid, bus.out_data, exp_a[i]);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    do_clear();
    decim_ratio = 5'd3;
    push(longint'(1) <<< 17);
    push(longint'(2) <<< 17);
    decim_ratio = 5'd2;
    for (int k = 3; k <= 9; k++) push(longint'(k) <<< 17);
    idle(1);
    n_checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL decchg_level: lvl %0d ovf %b exp 4 0",
               fifo_level, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_data !== 18'(exp_b[i])) begin
        n_fail++;
        $display("FAIL decchg_%0d: v %b got %0d exp %0d",
                 i, bus.out_valid, bus.out_data, exp_b[i]);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(longint'(k) <<< 17);
    idle(1);
    n_checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: lvl %0d ovf %b exp 4 1",
               fifo_level, overflow);
    end
    idle(2);
    n_checks++;
    if (bus.out_data !== 18'sd1) begin
      n_fail++;
      $display("FAIL bp_stable: got %0d exp 1", bus.out_data);
    end
    for (int i = 1; i <= 4; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 ||
          bus.out_data !== 18'(i)) begin
        n_fail++;
        $display("FAIL bp_drain_%0d: v %b got %0d exp %0d",
                 i, bus.out_valid, bus.out_data, i);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: valid %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push(longint'(k) <<< 17);
    idle(1);
    push(longint'(5) <<< 17);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (fifo_level !== 3'd4 ||
          bus.out_data !== 18'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_%0d: lvl %0d got %0d exp 4 %0d",
                 i, fifo_level, bus.out_data, i + 1);
      end
      if (i < 5) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 38'(longint'(6 + i) <<< 17);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ovf: lvl %0d ovf %b exp 4 0",
               fifo_level, overflow);
    end
    for (int i = 7; i <= 10; i++) begin
      n_checks++;
      if (bus.out_data !== 18'(i)) begin
        n_fail++;
        $display("FAIL b2b_tail_%0d: got %0d exp %0d",
                 i, bus.out_data, i);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) push(longint'(k) <<< 17);
    idle(1);
    n_checks++;
    if (fifo_level !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_pre: lvl %0d exp 3", fifo_level);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 3'd0 ||
        bus.out_data !== 18'sd0) begin
      n_fail++;
      $display("FAIL rst_async: v %b lvl %0d d %0d exp 0 0 0",
               bus.out_valid, fifo_level, bus.out_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clear();
    do_clear();
    decim_ratio   = 5'd1;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(longint'(k) <<< 17);
    idle(1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (fifo_level !== 3'd3 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pre: lvl %0d ovf %b exp 3 1",
               fifo_level, overflow);
    end
    push(longint'(7) <<< 17);
    bus.in_valid  = 1'b1;
    bus.in_data   = 38'(longint'(8) <<< 17);
    bus.out_ready = 1'b1;
    clear         = 1'b1;
    @(negedge clk);
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || fifo_level !== 3'd0 ||
        overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_now: v %b lvl %0d ovf %b exp 0 0 0",
               bus.out_valid, fifo_level, overflow);
    end
    idle(2);
    n_checks++;
    if (fifo_level !== 3'd0 || sat_count !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_inflight: lvl %0d sat %0d exp 0 0",
               fifo_level, sat_count);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset_n       = 1'b0;
    clear         = 1'b0;
    decim_ratio   = 5'd1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_decimation();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
